// File: rtl/cla_multiword_seq_if.sv
// Requester-side bus of the multiword adder sequencer.
// The sub line exists only when CLA_SEQ_SUB_EN is defined.
interface cla_multiword_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef CLA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef CLA_SEQ_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/cla_multiword_seq.sv
// Adds WORDS*16-bit operands one 16-bit word per cycle through a single 16-bit CLA.
// Defining CLA_SEQ_SUB_EN adds a subtract mode (invert B, force carry-in to 1).
//
// state  | meaning
// S_IDLE | waiting for start; sum/cout hold the last result
// S_RUN  | one word per cycle through the CLA, LSW first; busy=1
// S_DONE | done=1 for one cycle; working word copied to sum/cout at its edge
module cla_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  cla_multiword_seq_if.slave  bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [WORDS-1:0][15:0]  a_q, a_d;
  logic [WORDS-1:0][15:0]  b_q, b_d;
  logic [WORDS-1:0][15:0]  work_q, work_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [W-1:0]            sum_q, sum_d;
  logic                    cout_q, cout_d;
`ifdef CLA_SEQ_SUB_EN
  logic                    sub_q, sub_d;
`endif

  logic [15:0] cla_a, cla_b, cla_s;
  logic        cla_ci, cla_co;
  logic [15:0] cla_g, cla_p;
  logic [3:0]  grp_g, grp_p;
  logic        grp_c, bit_c;
  logic        accept;

  // Start is honoured in IDLE and in DONE, so back-to-back operations lose no cycle.
  assign accept = bus.start && (state_q != S_RUN);

  assign cla_a  = a_q[idx_q];
`ifdef CLA_SEQ_SUB_EN
  assign cla_b  = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
  assign cla_b  = b_q[idx_q];
`endif
  assign cla_ci = carry_q;

  always_comb begin
    cla_g = cla_a & cla_b;
    cla_p = cla_a ^ cla_b;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < 4; j++) begin
      grp_g[j] = cla_g[4*j+3]
               | (cla_p[4*j+3] & cla_g[4*j+2])
               | ((&cla_p[4*j+2 +: 2]) & cla_g[4*j+1])
               | ((&cla_p[4*j+1 +: 3]) & cla_g[4*j]);
      grp_p[j] = &cla_p[4*j +: 4];
    end
  end

  // Group carries come from group generate/propagate; bit carries only inside a nibble.
  always_comb begin
    cla_s = '0;
    grp_c = cla_ci;
    bit_c = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bit_c = grp_c;
      for (int i = 0; i < 4; i++) begin
        cla_s[4*j+i] = cla_p[4*j+i] ^ bit_c;
        bit_c        = cla_g[4*j+i] | (cla_p[4*j+i] & bit_c);
      end
      grp_c = grp_g[j] | (grp_p[j] & grp_c);
    end
    cla_co = grp_c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_RUN: begin
        work_d[idx_q] = cla_s;
        carry_d       = cla_co;
        if (idx_q == IW'(WORDS - 1)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        sum_d   = work_q;
        cout_d  = carry_q;
        state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      idx_d   = '0;
      state_d = S_RUN;
`ifdef CLA_SEQ_SUB_EN
      sub_d   = bus.sub;
      carry_d = bus.sub ? 1'b1 : bus.cin;
`else
      carry_d = bus.cin;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Randomised self-checking bench for cla_multiword_seq against an arithmetic model.
module tb_cla_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam int WP    = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cla_multiword_seq_if #(.WORDS(WORDS)) bus();
  cla_multiword_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [W:0]  exp_prev;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {cout,sum}: W+1-bit add, or for subtract the W-bit difference with cout = no borrow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    if (s) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
`ifdef CLA_SEQ_SUB_EN
    bus.sub   = s;
`else
    if (s) $display("note: sub requested without subtract support");
`endif
  endtask

  // Called one step after the accepting edge; returns in the done cycle (or on budget expiry).
  task automatic wait_done(input int glitch_at, output int busy_n, output bit ok);
    busy_n = 0;
    ok     = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      check("hold_during_run", {bus.cout, bus.sum}, exp_prev);
      if (t == glitch_at) drive(1'b1, 1, 1, 1'b1, 1'b0);
      else bus.start = 1'b0;
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input int glitch_at);
    logic [W:0] exp;
    int         bn;
    bit         ok;
    exp = model(a, b, c, s);
    drive(1'b1, a, b, c, s);
    step();
    bus.start = 1'b0;
    wait_done(glitch_at, bn, ok);
    check("done_seen", WP'(ok), WP'(1));
    check("busy_cycles", WP'(bn), WP'(WORDS));
    check("busy_low_in_done", WP'(bus.busy), WP'(0));
    check("no_partial_in_done", {bus.cout, bus.sum}, exp_prev);
    step();
    check("done_one_cycle", WP'(bus.done), WP'(0));
    check("result", {bus.cout, bus.sum}, exp);
    exp_prev = exp;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    logic [W:0]   exp_a, exp_b;
    int           bn;
    bit           ok;

    exp_prev = '0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    check("reset_flags", WP'({bus.busy, bus.done}), WP'(0));
    check("reset_sum", {bus.cout, bus.sum}, '0);
    rst = 1'b0;
    step();

    run_op({W{1'b1}}, 1, 1'b0, 1'b0, -1);
    run_op(64'h0000_1234_0000_FFFF, 64'h0000_0001_0000_0000, 1'b1, 1'b0, -1);

    // A second start mid-run must be ignored and must not produce a second done.
    run_op(5, 7, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      check("single_done", WP'(bus.done), WP'(0));
      step();
    end

    // Asynchronous reset while idle with a nonzero result held.
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", WP'({bus.busy, bus.done}), WP'(0));
    check("async_rst_sum", {bus.cout, bus.sum}, '0);
    exp_prev = '0;
    step();
    rst = 1'b0;
    step();

    // Abort two cycles into RUN.
    run_op(100, 200, 1'b0, 1'b0, -1);
    drive(1'b1, 64'hDEAD, 64'hBEEF, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("abort_flags", WP'({bus.busy, bus.done}), WP'(0));
    check("abort_sum", {bus.cout, bus.sum}, '0);
    exp_prev = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done", WP'({bus.busy, bus.done}), WP'(0));
    end
    run_op(3, 4, 1'b0, 1'b0, -1);

    // Back-to-back: second start presented in the DONE cycle.
    exp_a = model(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    exp_b = model(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b0);
    drive(1'b1, 64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    wait_done(-1, bn, ok);
    check("b2b_first_done", WP'(ok), WP'(1));
    drive(1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    check("b2b_first_result", {bus.cout, bus.sum}, exp_a);
    check("b2b_accepted", WP'(bus.busy), WP'(1));
    exp_prev = exp_a;
    wait_done(-1, bn, ok);
    check("b2b_second_done", WP'(ok), WP'(1));
    check("b2b_busy_cycles", WP'(bn), WP'(WORDS));
    step();
    check("b2b_second_result", {bus.cout, bus.sum}, exp_b);
    exp_prev = exp_b;

`ifdef CLA_SEQ_SUB_EN
    run_op(10, 3, 1'b0, 1'b1, -1);
    run_op(3, 10, 1'b1, 1'b1, -1);
`endif

    for (int n = 0; n < 200; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef CLA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      if (n % 16 == 0) ra = {W{1'b1}};
      if (n % 16 == 8) rb = '0;
      run_op(ra, rb, rc, rs, (n % 4 == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
